// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet source.
// Header byte layout: length in [7:2], destination port in [1:0].
package router_pkg;

    localparam int HDR_LEN_W  = 6;
    localparam int HDR_DEST_W = 2;

    localparam logic [HDR_DEST_W-1:0] DEST_INVALID = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HDR,
        ST_PAY,
        ST_PAR,
        ST_GAP
    } src_state_e;

    function automatic logic [7:0] pack_hdr(input logic [HDR_LEN_W-1:0]  len,
                                            input logic [HDR_DEST_W-1:0] dest);
        return {len, dest};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// 64x8 payload store: written sequentially while loading, read sequentially while sending.
// Read data is combinational from the read pointer; both pointers clear on command accept.
// No backpressure of its own: the caller gates wr_en and rd_adv.
module router_tx_buf (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_adv,
    output logic [5:0] wr_ptr,
    output logic [5:0] rd_ptr,
    output logic [7:0] rd_data
);

    logic [7:0] mem_q [64];
    logic [5:0] wr_ptr_q, wr_ptr_d;
    logic [5:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en)  wr_ptr_d = wr_ptr_q + 6'd1;
            if (rd_adv) rd_ptr_d = rd_ptr_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: stale bytes are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign wr_ptr  = wr_ptr_q;
    assign rd_ptr  = rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/router_pkt_src.sv
// Store-and-forward packet source feeding the 1x3 router: command, payload load, then header/payload/parity.
// Header appears the cycle after the last payload byte is loaded; one beat per non-busy edge after that.
// busy freezes data_out/pkt_valid in place; cmd_ready only in IDLE, pl_ready only while loading.
module router_pkt_src
    import router_pkg::*;
#(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [HDR_DEST_W-1:0] cmd_dest,
    input  logic [HDR_LEN_W-1:0]  cmd_len,
    output logic                  cmd_err,
    input  logic [7:0]            pl_data,
    input  logic                  pl_valid,
    output logic                  pl_ready,
    input  logic                  busy,
    output logic                  pkt_valid,
    output logic [7:0]            data_out,
    output logic                  done
);

    localparam logic [6:0]       MAX_LEN_L = 7'(MAX_LEN);
    localparam int               GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    src_state_e            state_q, state_d;
    logic [HDR_DEST_W-1:0] dest_q, dest_d;
    logic [HDR_LEN_W-1:0]  len_q, len_d;
    logic [7:0]            par_q, par_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [7:0]            data_out_q, data_out_d;
    logic                  pkt_valid_q, pkt_valid_d;
    logic                  cmd_err_q, cmd_err_d;
    logic                  done_q, done_d;

    logic       buf_clr, buf_wr, buf_rd;
    logic [5:0] wr_ptr, rd_ptr;
    logic [7:0] rd_data;
    logic       cmd_bad;
    logic       xfer;

    router_tx_buf u_buf (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (pl_data),
        .rd_adv  (buf_rd),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_data)
    );

    assign cmd_bad = (cmd_dest == DEST_INVALID) || (cmd_len == '0) ||
                     ({1'b0, cmd_len} > MAX_LEN_L);
    assign xfer    = !busy;

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        len_d       = len_q;
        par_d       = par_q;
        gap_d       = gap_q;
        data_out_d  = data_out_q;
        pkt_valid_d = pkt_valid_q;
        cmd_err_d   = 1'b0;
        done_d      = 1'b0;
        buf_clr     = 1'b0;
        buf_wr      = 1'b0;
        buf_rd      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        dest_d  = cmd_dest;
                        len_d   = cmd_len;
                        par_d   = pack_hdr(cmd_len, cmd_dest);
                        buf_clr = 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (pl_valid) begin
                    buf_wr = 1'b1;
                    par_d  = par_q ^ pl_data;
                    if (wr_ptr == len_q - 6'd1) begin
                        data_out_d  = pack_hdr(len_q, dest_q);
                        pkt_valid_d = 1'b1;
                        state_d     = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    data_out_d = rd_data;
                    buf_rd     = 1'b1;
                    state_d    = ST_PAY;
                end
            end
            ST_PAY: begin
                // rd_ptr counts bytes already presented; reaching len means the last one just went.
                if (xfer) begin
                    if (rd_ptr == len_q) begin
                        data_out_d  = par_q;
                        pkt_valid_d = 1'b0;
                        state_d     = ST_PAR;
                    end else begin
                        data_out_d = rd_data;
                        buf_rd     = 1'b1;
                    end
                end
            end
            ST_PAR: begin
                if (xfer) begin
                    done_d     = 1'b1;
                    data_out_d = '0;
                    gap_d      = '0;
                    state_d    = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
                else                   gap_d   = gap_q + GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            dest_q      <= '0;
            len_q       <= '0;
            par_q       <= '0;
            gap_q       <= '0;
            data_out_q  <= '0;
            pkt_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            len_q       <= len_d;
            par_q       <= par_d;
            gap_q       <= gap_d;
            data_out_q  <= data_out_d;
            pkt_valid_q <= pkt_valid_d;
            cmd_err_q   <= cmd_err_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign pl_ready  = (state_q == ST_LOAD);
    assign pkt_valid = pkt_valid_q;
    assign data_out  = data_out_q;
    assign cmd_err   = cmd_err_q;
    assign done      = done_q;

endmodule

// File: tb/tb_router_pkt_src.sv
// Bench for router_pkt_src: a router-side monitor applies busy stalls and checks each transferred beat
// against a queue of expected beats built from header/payload/XOR-parity rules.
module tb_router_pkt_src;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_dest = '0;
    logic [5:0] cmd_len = '0;
    logic [7:0] pl_data = '0;
    logic       pl_valid = 1'b0;
    logic       busy = 1'b0;
    logic       cmd_ready, cmd_err, pl_ready, pkt_valid, done;
    logic [7:0] data_out;

    always #5 clk = ~clk;

    router_pkt_src #(.MAX_LEN(63), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dest  (cmd_dest),
        .cmd_len   (cmd_len),
        .cmd_err   (cmd_err),
        .pl_data   (pl_data),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .busy      (busy),
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .done      (done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Shared between stimulus and monitor.
    logic [8:0] exp_q[$];          // {pkt_valid, data} per expected beat
    logic [7:0] pl_bytes [64];
    int         stall_plan [70];
    int         cyc = 0;
    int         cur_t, cur_len, cur_idle;
    int         done_cnt = 0;
    int         done_cyc = 0;
    bit         junk_pl = 0;

    // Monitor state.
    bit         in_pkt = 0, done_exp = 0, prev_stall = 0;
    int         beat = 0, held = 0, stalls = 0, gap_idx = -1;
    logic [7:0] prev_dat;
    logic       prev_vld;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        logic [8:0] e;
        if (!rstn) begin
            in_pkt     = 0;
            done_exp   = 0;
            prev_stall = 0;
            gap_idx    = -1;
            busy       = 1'b0;
        end else begin
            chk("done", done, done_exp);
            if (done_exp) begin
                done_cnt++;
                done_cyc = cyc;
                chk("latency", cyc - cur_t, 2 * cur_len + 2 + cur_idle + stalls);
                chk("beat_cnt", beat, cur_len + 2);
                chk("post_par_dat", data_out, 0);
                chk("post_par_vld", pkt_valid, 0);
                gap_idx = 0;
            end
            done_exp = 0;
            if (gap_idx >= 0) begin
                chk("cmd_ready_gap", cmd_ready, gap_idx == GAP);
                gap_idx = (gap_idx == GAP) ? -1 : gap_idx + 1;
            end
            if (prev_stall) begin
                chk("hold_dat", data_out, prev_dat);
                chk("hold_vld", pkt_valid, prev_vld);
            end
            if (!in_pkt && pkt_valid) begin
                in_pkt = 1; beat = 0; held = 0; stalls = 0;
            end
            prev_stall = 0;
            busy = 1'b0;
            if (in_pkt) begin
                if (beat < 70 && held < stall_plan[beat]) begin
                    busy = 1'b1; held++; stalls++; prev_stall = 1;
                end else begin
                    if (exp_q.size() == 0) chk("exp_underflow", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("beat_dat", data_out, e[7:0]);
                        chk("beat_vld", pkt_valid, e[8]);
                    end
                    if (!pkt_valid) begin in_pkt = 0; done_exp = 1; end
                    beat++; held = 0;
                end
            end
            prev_dat = data_out;
            prev_vld = pkt_valid;
        end
    end

    // pl_mode: 0 pl_valid held high, 1 random, 2 alternating. stall_mode: 0 none, 1 random, 2 preset.
    task automatic send_pkt(input logic [1:0] dest, input int len, input int pl_mode,
                            input int stall_mode, input bit b2b);
        logic [7:0] hdr, par;
        int k, idx, idle;
        bit v, tog;
        k = 0;
        while (!cmd_ready && k < 1000) begin @(negedge clk); k++; end
        chk("cmd_rdy_wait", cmd_ready, 1);
        hdr = 8'((len * 4 + dest) & 255);
        par = hdr;
        exp_q.push_back({1'b1, hdr});
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({1'b1, pl_bytes[i]});
            par = par ^ pl_bytes[i];
        end
        exp_q.push_back({1'b0, par});
        if (stall_mode != 2)
            for (int i = 0; i < 70; i++) stall_plan[i] = (stall_mode == 1) ? $urandom_range(0, 2) : 0;
        cmd_valid = 1'b1; cmd_dest = dest; cmd_len = 6'(len);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cur_t = cyc; cur_len = len; cur_idle = 0;
        if (b2b) chk("b2b_gap", cur_t - done_cyc, GAP + 1);
        idx = 0; idle = 0; tog = 0; k = 0;
        while (idx < len && k < 1000) begin
            v = (pl_mode == 0) ? 1'b1 : (pl_mode == 1) ? 1'($urandom_range(0, 1)) : tog;
            tog = !tog;
            chk("pl_ready", pl_ready, 1);
            pl_valid = v; pl_data = pl_bytes[idx];
            @(posedge clk);
            if (v) idx++; else idle++;
            @(negedge clk);
            k++;
        end
        cur_idle = idle;
        pl_valid = junk_pl;
        pl_data  = 8'hEE;
    endtask

    task automatic wait_pkts(input int target);
        int k = 0;
        while (done_cnt < target && k < 3000) begin @(negedge clk); k++; end
        chk("pkt_done_wait", done_cnt >= target, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!cmd_ready && k < 200) begin @(negedge clk); k++; end
        chk("idle_wait", cmd_ready, 1);
    endtask

    task automatic send_bad(input logic [1:0] d, input logic [5:0] l);
        cmd_valid = 1'b1; cmd_dest = d; cmd_len = l;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("err_pulse", cmd_err, 1);
        chk("err_rdy", cmd_ready, 1);
        chk("err_vld", pkt_valid, 0);
        chk("err_plrdy", pl_ready, 0);
        @(negedge clk);
        chk("err_clear", cmd_err, 0);
        chk("err_rdy2", cmd_ready, 1);
        chk("err_vld2", pkt_valid, 0);
    endtask

    initial begin : watchdog
        #500000;
        chk("global_timeout", 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : main
        int base, k;
        for (int i = 0; i < 70; i++) stall_plan[i] = 0;
        #2;
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_pl_ready", pl_ready, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Plain packet, no stalls.
        pl_bytes[0] = 8'h11; pl_bytes[1] = 8'h22; pl_bytes[2] = 8'h33;
        base = done_cnt;
        send_pkt(2'd1, 3, 0, 0, 0);
        wait_pkts(base + 1);

        // Same packet, 4 stalls on the header and 2 on byte 22.
        for (int i = 0; i < 70; i++) stall_plan[i] = 0;
        stall_plan[0] = 4; stall_plan[2] = 2;
        base = done_cnt;
        send_pkt(2'd1, 3, 0, 2, 0);
        wait_pkts(base + 1);
        chk("stall_total", stalls, 6);

        // Rejected commands.
        wait_idle();
        send_bad(2'd3, 6'd5);
        send_bad(2'd0, 6'd0);
        send_bad(2'd3, 6'd0);

        // Maximum length, alternating pl_valid, random stalls, stray pl_valid while sending.
        for (int i = 0; i < 64; i++) pl_bytes[i] = 8'($urandom);
        junk_pl = 1;
        base = done_cnt;
        send_pkt(2'd2, 63, 2, 1, 0);
        wait_pkts(base + 1);
        junk_pl = 0;
        pl_valid = 1'b0;

        // Reset in the middle of the payload.
        for (int i = 0; i < 64; i++) pl_bytes[i] = 8'($urandom);
        send_pkt(2'd2, 10, 0, 0, 0);
        k = 0;
        while (!(in_pkt && beat >= 6) && k < 200) begin @(negedge clk); k++; end
        chk("reach_byte4", beat >= 6, 1);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_pkt_valid", pkt_valid, 0);
        chk("arst_cmd_ready", cmd_ready, 1);
        chk("arst_data_out", data_out, 0);
        chk("arst_pl_ready", pl_ready, 0);
        @(negedge clk);
        exp_q.delete();
        @(posedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        pl_bytes[0] = 8'hAA;
        base = done_cnt;
        send_pkt(2'd0, 1, 0, 0, 0);
        wait_pkts(base + 1);

        // Back-to-back packets to every port.
        base = done_cnt;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 64; i++) pl_bytes[i] = 8'($urandom);
            send_pkt(2'(d), $urandom_range(1, 8), 1, 1, d != 0);
        end
        wait_pkts(base + 3);

        // Random packets.
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 64; i++) pl_bytes[i] = 8'($urandom);
            base = done_cnt;
            send_pkt(2'($urandom_range(0, 2)), $urandom_range(1, 63), $urandom_range(0, 1), 1, 0);
            wait_pkts(base + 1);
        end

        repeat (GAP + 3) @(negedge clk);
        chk("exp_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
